tour_cmd_seq: RTL and testbench

//  Replays a stored knight's tour as cmd_proc movement commands: each 1-hot move becomes one vertical and one

---
 rtl/tour_pkg.sv | 28 ++
 rtl/knight_move_dec.sv | 38 +++
 rtl/tour_cmd_seq.sv | 148 ++++++++++++++
 tb/tb_tour_cmd_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and default constants for the knight's-tour command sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        VERT,
        VERT_W,
        HORZ,
        HORZ_W,
        DRAIN
    } state_t;

    localparam logic [3:0] DEF_VERT_OP   = 4'h2;
    localparam logic [3:0] DEF_HORZ_OP   = 4'h3;
    localparam logic [3:0] DEF_ABORT_OP  = 4'hF;
    localparam logic [7:0] DEF_HEAD_N    = 8'h00;
    localparam logic [7:0] DEF_HEAD_S    = 8'h7F;
    localparam logic [7:0] DEF_HEAD_W    = 8'h3F;
    localparam logic [7:0] DEF_HEAD_E    = 8'hBF;
    localparam logic [7:0] DEF_RESP_DONE = 8'hA5;
    localparam logic [7:0] DEF_RESP_BUSY = 8'h5A;

    function automatic logic is_onehot8(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/knight_move_dec.sv
// Decodes a 1-hot knight move into its vertical and horizontal legs (heading + magnitude).
module knight_move_dec
    import tour_pkg::*;
#(
    parameter logic [7:0] HEAD_N = DEF_HEAD_N,
    parameter logic [7:0] HEAD_S = DEF_HEAD_S,
    parameter logic [7:0] HEAD_W = DEF_HEAD_W,
    parameter logic [7:0] HEAD_E = DEF_HEAD_E
) (
    input  logic [7:0] mv,
    output logic [7:0] vhead,
    output logic [3:0] vmag,
    output logic [7:0] hhead,
    output logic [3:0] hmag,
    output logic       illegal
);

    always_comb begin
        vhead = HEAD_N;
        vmag  = 4'd0;
        hhead = HEAD_W;
        hmag  = 4'd0;
        case (mv)
            8'h01: begin vhead = HEAD_N; vmag = 4'd2; hhead = HEAD_W; hmag = 4'd1; end
            8'h02: begin vhead = HEAD_N; vmag = 4'd2; hhead = HEAD_E; hmag = 4'd1; end
            8'h04: begin vhead = HEAD_N; vmag = 4'd1; hhead = HEAD_W; hmag = 4'd2; end
            8'h08: begin vhead = HEAD_S; vmag = 4'd1; hhead = HEAD_W; hmag = 4'd2; end
            8'h10: begin vhead = HEAD_S; vmag = 4'd2; hhead = HEAD_W; hmag = 4'd1; end
            8'h20: begin vhead = HEAD_S; vmag = 4'd2; hhead = HEAD_E; hmag = 4'd1; end
            8'h40: begin vhead = HEAD_S; vmag = 4'd1; hhead = HEAD_E; hmag = 4'd2; end
            8'h80: begin vhead = HEAD_N; vmag = 4'd1; hhead = HEAD_E; hmag = 4'd2; end
            default: ;
        endcase
    end

    assign illegal = !is_onehot8(mv);

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a stored knight's tour as vertical/horizontal cmd_proc commands, taking over the
// UART command path while a tour runs; a UART abort opcode ends the tour early.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES = 24,
    parameter int         IDX_W     = $clog2(NUM_MOVES),
    parameter logic [3:0] VERT_OP   = DEF_VERT_OP,
    parameter logic [3:0] HORZ_OP   = DEF_HORZ_OP,
    parameter logic [3:0] ABORT_OP  = DEF_ABORT_OP,
    parameter logic [7:0] HEAD_N    = DEF_HEAD_N,
    parameter logic [7:0] HEAD_S    = DEF_HEAD_S,
    parameter logic [7:0] HEAD_W    = DEF_HEAD_W,
    parameter logic [7:0] HEAD_E    = DEF_HEAD_E,
    parameter logic [7:0] RESP_DONE = DEF_RESP_DONE,
    parameter logic [7:0] RESP_BUSY = DEF_RESP_BUSY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_done,
    output logic             mv_err
);

    state_t      state, nxt;
    logic [7:0]  move_q;
    logic [7:0]  dec_in;
    logic [7:0]  vhead, hhead;
    logic [3:0]  vmag, hmag;
    logic        dec_illegal;
    logic        abort_pend;
    logic        last_mv;
    logic        is_abort;
    logic [15:0] vcmd, hcmd;

    // In FETCH the decoder sees the raw move so legality is known before it is latched.
    assign dec_in = (state == FETCH) ? move : move_q;

    knight_move_dec #(
        .HEAD_N(HEAD_N),
        .HEAD_S(HEAD_S),
        .HEAD_W(HEAD_W),
        .HEAD_E(HEAD_E)
    ) u_dec (
        .mv     (dec_in),
        .vhead  (vhead),
        .vmag   (vmag),
        .hhead  (hhead),
        .hmag   (hmag),
        .illegal(dec_illegal)
    );

    assign vcmd             = {VERT_OP, vhead, vmag};
    assign hcmd             = {HORZ_OP, hhead, hmag};
    assign last_mv          = (mv_indx == IDX_W'(NUM_MOVES - 1));
    assign tour_busy        = (state != IDLE);
    assign is_abort         = tour_busy && cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP) && !abort_pend;
    assign clr_cmd_rdy_UART = is_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (start_tour) nxt = FETCH;
            end
            FETCH: begin
                cmd = vcmd;
                nxt = (abort_pend || dec_illegal) ? IDLE : VERT;
            end
            VERT: begin
                cmd     = vcmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy)     nxt = VERT_W;
                else if (abort_pend) nxt = IDLE;
            end
            VERT_W: begin
                cmd = vcmd;
                if (abort_pend) resp = RESP_DONE;
                if (send_resp)       nxt = abort_pend ? IDLE : HORZ;
                else if (abort_pend) nxt = DRAIN;
            end
            HORZ: begin
                cmd     = hcmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy)     nxt = HORZ_W;
                else if (abort_pend) nxt = IDLE;
            end
            HORZ_W: begin
                cmd = hcmd;
                if (last_mv || abort_pend) resp = RESP_DONE;
                if (send_resp)       nxt = (last_mv || abort_pend) ? IDLE : FETCH;
                else if (abort_pend) nxt = DRAIN;
            end
            DRAIN: begin
                cmd  = hcmd;
                resp = RESP_DONE;
                if (send_resp) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign tour_done = (state != IDLE) && (nxt == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_indx    <= '0;
            move_q     <= 8'h00;
            abort_pend <= 1'b0;
            mv_err     <= 1'b0;
        end else begin
            if (state == IDLE && start_tour) begin
                mv_indx <= '0;
                mv_err  <= 1'b0;
            end else if (state == HORZ_W && nxt == FETCH) begin
                mv_indx <= mv_indx + IDX_W'(1);
            end
            if (state == FETCH) begin
                move_q <= move;
                if (dec_illegal) mv_err <= 1'b1;
            end
            if (nxt == IDLE)   abort_pend <= 1'b0;
            else if (is_abort) abort_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench: a 24-move and a 4-move sequencer share stimulus; expected commands and
// responses are queued by the stimulus and popped by an independent monitor.
module tb_tour_cmd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start24 = 1'b0, start4 = 1'b0;
    logic [7:0]  moves24 [24];
    logic [7:0]  moves4  [4];
    logic [7:0]  move24, move4;
    logic [4:0]  mv_indx24;
    logic [1:0]  mv_indx4;
    logic [15:0] cmd_UART = 16'h1234;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_a = 1'b0, clr_m = 1'b0, send_a = 1'b0, send_m = 1'b0;
    logic        clr_cmd_rdy, send_resp;
    logic        clr_uart24, clr_uart4, cmd_rdy24, cmd_rdy4, busy24, busy4, done24, done4, err24, err4;
    logic [15:0] cmd24, cmd4;
    logic [7:0]  resp24, resp4;

    logic        sel = 1'b0;
    logic [15:0] cmd_m;
    logic        cmd_rdy_m, busy_m, clr_uart_any;
    logic [7:0]  resp_m;

    assign move24       = moves24[mv_indx24];
    assign move4        = moves4[mv_indx4];
    assign clr_cmd_rdy  = clr_a | clr_m;
    assign send_resp    = send_a | send_m;
    assign cmd_m        = sel ? cmd24 : cmd4;
    assign cmd_rdy_m    = sel ? cmd_rdy24 : cmd_rdy4;
    assign busy_m       = sel ? busy24 : busy4;
    assign resp_m       = sel ? resp24 : resp4;
    assign clr_uart_any = clr_uart24 | clr_uart4;

    tour_cmd_seq u_dut24 (
        .clk(clk), .rst_n(rst_n), .start_tour(start24), .move(move24), .mv_indx(mv_indx24),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_uart24),
        .cmd(cmd24), .cmd_rdy(cmd_rdy24), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp24), .tour_busy(busy24), .tour_done(done24), .mv_err(err24)
    );

    tour_cmd_seq #(.NUM_MOVES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_tour(start4), .move(move4), .mv_indx(mv_indx4),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_uart4),
        .cmd(cmd4), .cmd_rdy(cmd_rdy4), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp4), .tour_busy(busy4), .tour_done(done4), .mv_err(err4)
    );

    int total = 0, bad = 0;
    int done_cnt = 0, clr_uart_cnt = 0;
    logic [15:0] cmd_q [$];
    logic [7:0]  resp_q [$];
    logic auto_en = 1'b0;
    logic uart_clr_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on each handshake
    initial forever begin
        @(negedge clk);
        if (clr_uart_any) begin clr_uart_cnt++; uart_clr_pend = 1'b1; end
        if (done24 | done4) done_cnt++;
        if (cmd_rdy_m && clr_cmd_rdy) begin
            if (cmd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL cmd_unexpected: got %h expected none", cmd_m);
            end else chk("cmd", {16'h0, cmd_m}, {16'h0, cmd_q.pop_front()});
        end
        if (send_resp) begin
            if (resp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL resp_unexpected: got %h expected none", resp_m);
            end else chk("resp", {24'h0, resp_m}, {24'h0, resp_q.pop_front()});
        end
    end

    // UART wrapper model: drops cmd_rdy_UART once the abort is consumed
    initial forever begin
        @(posedge clk); #1;
        if (uart_clr_pend) begin cmd_rdy_UART = 1'b0; uart_clr_pend = 1'b0; end
    end

    // cmd_proc model: accepts each tour command, responds two cycles later
    initial begin
        int ph = 0, dly = 0;
        forever begin
            @(posedge clk); #1;
            clr_a  = 1'b0;
            send_a = 1'b0;
            if (ph == 0) begin
                if (auto_en && busy_m && cmd_rdy_m) begin clr_a = 1'b1; ph = 1; dly = 0; end
            end else begin
                dly++;
                if (dly >= 2) begin send_a = 1'b1; ph = 0; end
            end
        end
    end

    task automatic pulse_start(input logic big);
        @(posedge clk); #1;
        if (big) start24 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start24 = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int maxc);
        logic ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_rdy(input string name, input int maxc);
        logic ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cmd_rdy_m) begin ok = 1'b1; break; end
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic accept_manual();
        @(posedge clk); #1 clr_m = 1'b1;
        @(posedge clk); #1 clr_m = 1'b0;
    endtask

    task automatic send_manual();
        @(posedge clk); #1 send_m = 1'b1;
        @(posedge clk); #1 send_m = 1'b0;
    endtask

    task automatic chk_queues(input string name);
        chk(name, cmd_q.size() + resp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0;
        logic [15:0] t2_cmds [8];
        t2_cmds = '{16'h2002, 16'h3BF1, 16'h27F1, 16'h33F2, 16'h27F2, 16'h3BF1, 16'h2001, 16'h3BF2};
        for (int i = 0; i < 24; i++) moves24[i] = 8'h01;
        moves4 = '{8'h02, 8'h08, 8'h20, 8'h80};

        // reset state
        #12;
        chk("rst_busy", {30'h0, busy24, busy4}, 0);
        chk("rst_indx", {25'h0, mv_indx24, mv_indx4}, 0);
        chk("rst_err", {30'h0, err24, err4}, 0);
        chk("rst_cmd", {16'h0, cmd_m}, 32'h1234);
        chk("rst_cmd_rdy", {31'h0, cmd_rdy_m}, 0);
        chk("rst_resp", {24'h0, resp_m}, 32'hA5);
        chk("rst_pulses", {30'h0, clr_uart_any, done4 | done24}, 0);
        @(negedge clk) rst_n = 1'b1;

        // T1: 24 moves of 8'h01
        sel = 1'b1; auto_en = 1'b1;
        for (int i = 0; i < 24; i++) begin cmd_q.push_back(16'h2002); cmd_q.push_back(16'h33F1); end
        for (int i = 0; i < 48; i++) resp_q.push_back(i == 47 ? 8'hA5 : 8'h5A);
        d0 = done_cnt;
        pulse_start(1'b1);
        @(negedge clk);
        chk("t1_lat_fetch", {30'h0, busy_m, cmd_rdy_m}, 32'h2);
        @(negedge clk);
        chk("t1_lat_vert", {15'h0, cmd_rdy_m, cmd_m}, 32'h1_2002);
        wait_done("t1_done", d0, 1000);
        repeat (4) @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_indx", {27'h0, mv_indx24}, 23);
        chk("t1_busy", {31'h0, busy_m}, 0);
        chk_queues("t1_queues");

        // T2: 4 moves 02,08,20,80
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(t2_cmds[i]);
            resp_q.push_back(i == 7 ? 8'hA5 : 8'h5A);
        end
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_done("t2_done", d0, 500);
        repeat (2) @(negedge clk);
        chk("t2_indx", {30'h0, mv_indx4}, 3);
        chk("t2_done_once", done_cnt - d0, 1);
        chk_queues("t2_queues");

        // T3: illegal move at index 2
        moves4[2] = 8'h03;
        for (int i = 0; i < 4; i++) begin cmd_q.push_back(t2_cmds[i]); resp_q.push_back(8'h5A); end
        d0 = done_cnt;
        pulse_start(1'b0);
        wait_done("t3_done", d0, 500);
        repeat (3) @(negedge clk);
        chk("t3_err", {31'h0, err4}, 1);
        chk("t3_busy", {31'h0, busy4}, 0);
        chk("t3_indx", {30'h0, mv_indx4}, 2);
        chk_queues("t3_queues");
        moves4[2] = 8'h20;

        // T4b: abort while VERT waits for acceptance
        auto_en = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b0);
        @(negedge clk);
        chk("t4_err_clr", {31'h0, err4}, 0);
        wait_rdy("t4b_rdy", 10);
        c0 = clr_uart_cnt;
        @(posedge clk); #1 cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        wait_done("t4b_done", d0, 10);
        @(negedge clk);
        chk("t4b_clr_uart", clr_uart_cnt - c0, 1);
        chk("t4b_idle", {30'h0, busy4, cmd_rdy_m}, 0);
        chk_queues("t4b_queues");

        // T4a: abort in VERT_W, drained by send_resp
        pulse_start(1'b0);
        wait_rdy("t4a_rdy", 10);
        cmd_q.push_back(16'h2002);
        accept_manual();
        c0 = clr_uart_cnt;
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4a_drain", {22'h0, busy4, cmd_rdy4, resp4}, 32'h2A5);
        resp_q.push_back(8'hA5);
        d0 = done_cnt;
        send_manual();
        wait_done("t4a_done", d0, 10);
        @(negedge clk);
        chk("t4a_clr_uart", clr_uart_cnt - c0, 1);
        chk("t4a_busy", {31'h0, busy4}, 0);
        chk_queues("t4a_queues");

        // T5: pass-through in IDLE; non-abort UART cmd held during a tour
        @(posedge clk); #1 cmd_UART = 16'h2305; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        chk("t5_pass", {15'h0, cmd_rdy_m, cmd_m}, 32'h1_2305);
        @(posedge clk); #1 cmd_rdy_UART = 1'b0;
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(t2_cmds[i]);
            resp_q.push_back(i == 7 ? 8'hA5 : 8'h5A);
        end
        d0 = done_cnt;
        c0 = clr_uart_cnt;
        pulse_start(1'b0);
        cmd_rdy_UART = 1'b1;
        wait_done("t5_done", d0, 500);
        @(negedge clk);
        chk("t5_not_consumed", clr_uart_cnt - c0, 0);
        chk("t5_fwd_after", {15'h0, cmd_rdy_m, cmd_m}, 32'h1_2305);
        chk_queues("t5_queues");
        @(posedge clk); #1 cmd_rdy_UART = 1'b0;
        auto_en = 1'b0;

        // T6: async reset in HORZ_W
        pulse_start(1'b0);
        wait_rdy("t6_vrdy", 10);
        cmd_q.push_back(16'h2002);
        accept_manual();
        resp_q.push_back(8'h5A);
        send_manual();
        wait_rdy("t6_hrdy", 10);
        cmd_q.push_back(16'h3BF1);
        accept_manual();
        cmd_rdy_UART = 1'b1;
        @(negedge clk);
        chk("t6_pre_busy", {31'h0, busy4}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", {28'h0, busy4, mv_indx4, err4}, 0);
        chk("t6_rst_pass", {15'h0, cmd_rdy_m, cmd_m}, 32'h1_2305);
        @(negedge clk) rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        chk_queues("t6_queues");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
